shift_row_pipe: RTL and testbench
=================================

Name: shift_row_pipe

Overview:
Pipelined, parametrised Rijndael ShiftRows/InvShiftRows engine for the AES datapath. It is the successor to the combinational shift_row and adds four things: a selectable forward/inverse mode per block, Rijndael block widths Nb = 4/6/8 columns, a configurable register depth, and a valid/ready stream handshake with backpressure. It sits between SubBytes and MixColumns in the round pipeline and also feeds the decrypt path.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; data width W = 32*NB.
PIPE_DEPTH, 2, register stages; legal values 1 to 4; equals latency in cycles.
COUNT_WIDTH, 32, width of blockCount.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
inputData  input  W  state, column-major; byte 0 (row0,col0) in [W-1:W-8], byte k = row k%4, column k/4.
inputValid  input  1  inputData and inverseMode are valid.
inverseMode  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the block.
inputReady  output  1  block accepted when inputValid && inputReady.
outputData  output  W  transformed state, same byte ordering as inputData.
outputValid  output  1  outputData is valid.
outputReady  input  1  downstream accepts when outputValid && outputReady.
blockCount  output  COUNT_WIDTH  number of blocks delivered on the output.
busy  output  1  at least one pipeline stage holds a block.

Behaviour:
- Shift offsets: row0 = 0 and row1 = 1 for every NB; row2 = 2, row3 = 3 for NB = 4 or 6; row2 = 3, row3 = 4 for NB = 8.
- Forward transform: out[r][c] = in[r][(c + s_r) mod NB].
- Inverse transform: out[r][c] = in[r][(c - s_r + NB) mod NB].
- The transform is applied combinationally at the input. The result is captured in stage 1 and then moves through stages 2 to PIPE_DEPTH. Each stage holds a data register and a valid bit.
- Stage i loads when it is empty or when stage i+1 can accept. The last stage can accept when it is empty or outputReady = 1.
- inputReady = (stage 1 can accept). It is combinational from outputReady through the stage valid bits.
- Throughput: 1 block per cycle when outputReady is held at 1.
- Latency: PIPE_DEPTH cycles from the accepting edge to outputValid = 1, with no stalls.
- No bubbles are allowed while stalled. While outputValid && !outputReady, outputData is held stable, and an empty upstream stage still accepts a new block.
- Blocks leave in the order they were accepted. Each block keeps the mode it was accepted with, so forward and inverse blocks may be mixed back to back.
- blockCount increments on every output handshake. It wraps to 0 after 2^COUNT_WIDTH - 1.
- busy = OR of all stage valid bits.
- Reset (asynchronous, any time, including mid-stream) clears all valid bits, all data registers and blockCount to 0. In-flight blocks are discarded.
- Outputs while reset is held: outputValid = 0, outputData = 0, busy = 0, blockCount = 0.
- inputReady is 1 as soon as reset deasserts.
- inputData is ignored when inputValid = 0. No X may propagate into the valid bits.
- Illegal NB or PIPE_DEPTH values stop elaboration (generate-time error).

Test Plan:
1. Forward, NB = 4, PIPE_DEPTH = 2. Drive 63cab7040953d051cd60e0e7ba70e18c with outputReady = 1.
   Required: outputData = 6353e08c0960e104cd70b751bacad0e7, outputValid = 1 exactly 2 cycles after acceptance, blockCount = 1.
2. Inverse, NB = 4. Drive 6353e08c0960e104cd70b751bacad0e7 with inverseMode = 1.
   Required: 63cab7040953d051cd60e0e7ba70e18c.
   Then drive 000102...0f forward and 000102...0f inverse on back-to-back cycles.
   Required: 00050a0f04090e03080d02070c01060b, then 000d0a0704010e0b0805020f0c090603, on consecutive cycles.
3. NB = 8, forward. Drive bytes 00..1f.
   Required: column 0 = 00050e13, column 7 = 1c010a0f.
   Feed that output back with inverseMode = 1. Required: bytes 00..1f restored.
4. Backpressure, PIPE_DEPTH = 3. Stream 6 distinct blocks with outputReady = 0 for 5 cycles.
   Required: inputReady drops after 3 blocks are accepted, outputData is stable while stalled, and all 6 blocks emerge in order, each correctly transformed.
   Required: blockCount = 6 and busy = 0 afterwards.
5. Reset mid-stream. Assert reset asynchronously (mid-cycle) with 2 blocks in flight.
   Required: outputValid, busy and blockCount go to 0 immediately. The next block accepted after reset produces the correct output with no stale data.
6. Wrap, COUNT_WIDTH = 4. Deliver 17 blocks.
   Required: blockCount reads 1.

Source files
------------

// File: rtl/shift_row_pipe.sv
//------------------------------------------------------------------------------
// shift_row_pipe
// Pipelined Rijndael ShiftRows / InvShiftRows engine with a valid/ready stream
// interface. The byte permutation is applied combinationally at the input.
// The permuted state then passes through PIPE_DEPTH register stages that
// support backpressure.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   inputData    W-bit state, column-major, byte 0 (row0,col0) in [W-1:W-8]
//   inputValid   inputData / inverseMode are valid
//   inverseMode  0 = ShiftRows, 1 = InvShiftRows (travels with the block)
//   inputReady   block accepted when inputValid && inputReady
//   outputData   transformed state, same byte ordering as inputData
//   outputValid  outputData is valid
//   outputReady  downstream accepts when outputValid && outputReady
//   blockCount   number of output handshakes (wraps)
//   busy         at least one pipeline stage holds a block
//------------------------------------------------------------------------------
module shift_row_pipe #(
   parameter int NB          = 4,
   parameter int PIPE_DEPTH  = 2,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [32*NB-1:0]       inputData,
   input  logic                   inputValid,
   input  logic                   inverseMode,
   output logic                   inputReady,
   output logic [32*NB-1:0]       outputData,
   output logic                   outputValid,
   input  logic                   outputReady,
   output logic [COUNT_WIDTH-1:0] blockCount,
   output logic                   busy
);

   localparam int W = 32 * NB;

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("shift_row_pipe: NB must be 4, 6 or 8");
      end
      if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
         $error("shift_row_pipe: PIPE_DEPTH must be 1 to 4");
      end
   endgenerate

   // Byte permutation. Every output byte (row gr, column gc) is a fixed
   // rewiring of an input byte, so both directions are pure wiring and only
   // the final mux depends on inverseMode.
   logic [W-1:0] fwd_w;
   logic [W-1:0] inv_w;
   logic [W-1:0] xform_w;

   for (genvar gc = 0; gc < NB; gc++) begin : g_col
      for (genvar gr = 0; gr < 4; gr++) begin : g_row
         // Row offsets: rows 2 and 3 shift one further for the 256-bit block.
         localparam int SH   = (gr == 0) ? 0 : (gr == 1) ? 1 : (NB == 8) ? gr + 1 : gr;
         localparam int FSRC = (gc + SH) % NB;
         localparam int ISRC = (gc - SH + NB) % NB;
         assign fwd_w[W-1-8*(4*gc+gr) -: 8] = inputData[W-1-8*(4*FSRC+gr) -: 8];
         assign inv_w[W-1-8*(4*gc+gr) -: 8] = inputData[W-1-8*(4*ISRC+gr) -: 8];
      end
   end

   assign xform_w = inverseMode ? inv_w : fwd_w;

   // Pipeline stages
   logic [PIPE_DEPTH-1:0] valid_vec;
   logic [PIPE_DEPTH-1:0] accept_w;
   logic [W-1:0]          stage_data_w [PIPE_DEPTH];

   for (genvar gs = 0; gs < PIPE_DEPTH; gs++) begin : g_stage
      logic         up_valid;
      logic [W-1:0] up_data;
      logic         valid_q, valid_d;
      logic [W-1:0] data_q, data_d;

      // A stage can take a new block unless it and every stage downstream
      // of it are full while the output is stalled. Writing the ready chain
      // in this closed form avoids a combinational chain through a vector.
      assign accept_w[gs] = outputReady | ~(&valid_vec[PIPE_DEPTH-1:gs]);

      if (gs == 0) begin : g_first
         assign up_valid = inputValid;
         assign up_data  = xform_w;
      end else begin : g_next
         assign up_valid = valid_vec[gs-1];
         assign up_data  = stage_data_w[gs-1];
      end

      always_comb begin
         valid_d = valid_q;
         data_d  = data_q;
         if (accept_w[gs]) begin
            valid_d = up_valid;
            // Data only moves with a valid block, so idle input is ignored
            // and a stalled output word never changes.
            if (up_valid) begin
               data_d = up_data;
            end
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end

      assign valid_vec[gs]    = valid_q;
      assign stage_data_w[gs] = data_q;
   end

   // Output handshake counter
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (outputValid && outputReady) begin
         count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign inputReady  = accept_w[0];
   assign outputData  = stage_data_w[PIPE_DEPTH-1];
   assign outputValid = valid_vec[PIPE_DEPTH-1];
   assign blockCount  = count_q;
   assign busy        = |valid_vec;

endmodule

// File: tb/tb_shift_row_pipe.sv
//------------------------------------------------------------------------------
// tb_shift_row_pipe
// Two instances: A (NB=4, PIPE_DEPTH=2, 32-bit count) and B (NB=8,
// PIPE_DEPTH=3, 4-bit count). Expected results are pushed to a per-instance
// queue when a block is accepted and compared when the block leaves.
//------------------------------------------------------------------------------
module tb_shift_row_pipe;

   logic clk;
   logic rst;

   // instance A
   logic [127:0] a_in, a_out;
   logic         a_iv, a_inv, a_ir, a_ov, a_or, a_busy;
   logic [31:0]  a_cnt;
   // instance B
   logic [255:0] b_in, b_out;
   logic         b_iv, b_inv, b_ir, b_ov, b_or, b_busy;
   logic [3:0]   b_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int a_last_cyc = 0;
   int a_prev_cyc = 0;
   int b_acc  = 0;

   logic [255:0] qa[$];
   logic [255:0] qb[$];

   typedef struct {
      logic [255:0] din;
      bit           inv;
      logic [255:0] exp;
   } vec_t;

   vec_t tbl_a[4];
   vec_t tbl_b[2];

   shift_row_pipe #(.NB(4), .PIPE_DEPTH(2), .COUNT_WIDTH(32)) dut_a (
      .clock(clk), .reset(rst),
      .inputData(a_in), .inputValid(a_iv), .inverseMode(a_inv), .inputReady(a_ir),
      .outputData(a_out), .outputValid(a_ov), .outputReady(a_or),
      .blockCount(a_cnt), .busy(a_busy)
   );

   shift_row_pipe #(.NB(8), .PIPE_DEPTH(3), .COUNT_WIDTH(4)) dut_b (
      .clock(clk), .reset(rst),
      .inputData(b_in), .inputValid(b_iv), .inverseMode(b_inv), .inputReady(b_ir),
      .outputData(b_out), .outputValid(b_ov), .outputReady(b_or),
      .blockCount(b_cnt), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ShiftRows on the low nb*32 bits of d.
   function automatic logic [255:0] ref_sr(input logic [255:0] d, input int nb, input bit inv);
      logic [255:0] r;
      int s[4];
      int src;
      r = '0;
      s[0] = 0;
      s[1] = 1;
      s[2] = (nb == 8) ? 3 : 2;
      s[3] = (nb == 8) ? 4 : 3;
      for (int c = 0; c < nb; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            src = inv ? (c - s[rr] + nb) % nb : (c + s[rr]) % nb;
            r[nb*32-1-8*(4*c+rr) -: 8] = d[nb*32-1-8*(4*src+rr) -: 8];
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Scoreboard monitors: sampled on the falling edge, when the handshake
   // that completes on the next rising edge is already settled.
   always @(negedge clk) begin
      if (!rst && a_ov && a_or) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_output", a_out, 256'h0 - 1);
         end else begin
            chk("a_out", {128'h0, a_out}, qa.pop_front());
         end
         a_prev_cyc = a_last_cyc;
         a_last_cyc = cyc;
      end
   end

   always @(negedge clk) begin
      if (!rst && b_ov && b_or) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_output", b_out, ~b_out);
         end else begin
            chk("b_out", b_out, qb.pop_front());
         end
      end
   end

   // Senders: called #1 after a rising edge, return #1 after the accepting edge.
   task automatic send_a(input logic [255:0] d, input bit inv, input logic [255:0] e);
      bit done = 0;
      a_iv = 1'b1; a_in = d[127:0]; a_inv = inv;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (a_ir) begin
            qa.push_back(e);
            done = 1;
         end
         @(posedge clk);
      end
      if (!done) chk("a_send_timeout", 0, 1);
      #1;
   endtask

   task automatic send_b(input logic [255:0] d, input bit inv, input logic [255:0] e);
      bit done = 0;
      b_iv = 1'b1; b_in = d; b_inv = inv;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (b_ir) begin
            qb.push_back(e);
            done = 1;
         end
         @(posedge clk);
      end
      if (done) b_acc++;
      else chk("b_send_timeout", 0, 1);
      #1;
   endtask

   task automatic idle_a();
      a_iv = 1'b0; a_in = '0; a_inv = 1'b0;
   endtask

   task automatic idle_b();
      b_iv = 1'b0; b_in = '0; b_inv = 1'b0;
   endtask

   task automatic drain_a();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!a_busy && qa.size() == 0) done = 1;
      end
      if (!done) chk("a_drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic drain_b();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!b_busy && qb.size() == 0) done = 1;
      end
      if (!done) chk("b_drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      qa.delete();
      qb.delete();
   endtask

   logic [255:0] fb;
   logic [255:0] d;
   logic [255:0] orig;
   bit           got;

   initial begin
      tbl_a[0] = '{din: 256'h63cab7040953d051cd60e0e7ba70e18c, inv: 1'b0,
                   exp: 256'h6353e08c0960e104cd70b751bacad0e7};
      tbl_a[1] = '{din: 256'h6353e08c0960e104cd70b751bacad0e7, inv: 1'b1,
                   exp: 256'h63cab7040953d051cd60e0e7ba70e18c};
      tbl_a[2] = '{din: 256'h000102030405060708090a0b0c0d0e0f, inv: 1'b0,
                   exp: 256'h00050a0f04090e03080d02070c01060b};
      tbl_a[3] = '{din: 256'h000102030405060708090a0b0c0d0e0f, inv: 1'b1,
                   exp: 256'h000d0a0704010e0b0805020f0c090603};
      orig     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      tbl_b[0] = '{din: orig, inv: 1'b0,
                   exp: 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f};
      tbl_b[1] = '{din: 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f,
                   inv: 1'b1, exp: orig};

      rst = 1'b1;
      idle_a(); idle_b();
      a_or = 1'b1; b_or = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_a_ov",   a_ov, 0);
      chk("rst_a_out",  a_out, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_cnt",  a_cnt, 0);
      chk("rst_b_ov",   b_ov, 0);
      rst = 1'b0;
      #1 chk("rst_a_ready", a_ir, 1);

      // 1. Latency of a single forward block on A
      @(posedge clk); #1;
      send_a(tbl_a[0].din, 1'b0, tbl_a[0].exp);
      idle_a();
      chk("lat_a_ov_cycle1", a_ov, 0);
      @(posedge clk); #1;
      chk("lat_a_ov_cycle2", a_ov, 1);
      @(posedge clk); #1;
      chk("lat_a_cnt", a_cnt, 1);

      // 2. Table vectors on A, back to back
      for (int i = 0; i < 4; i++) send_a(tbl_a[i].din, tbl_a[i].inv, tbl_a[i].exp);
      idle_a();
      drain_a();
      chk("tbl_a_consecutive", a_last_cyc - a_prev_cyc, 1);
      chk("tbl_a_cnt", a_cnt, 5);

      // 5. Asynchronous reset with two blocks in flight
      a_or = 1'b0;
      send_a(tbl_a[2].din, 1'b0, tbl_a[2].exp);
      send_a(tbl_a[3].din, 1'b1, tbl_a[3].exp);
      idle_a();
      chk("pre_rst_a_busy", a_busy, 1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("midrst_a_ov",   a_ov, 0);
      chk("midrst_a_busy", a_busy, 0);
      chk("midrst_a_cnt",  a_cnt, 0);
      chk("midrst_a_out",  a_out, 0);
      qa.delete();
      @(negedge clk); #1;
      rst = 1'b0;
      #1 chk("postrst_a_ready", a_ir, 1);
      @(posedge clk); #1;
      a_or = 1'b1;
      d = {224'h0, $urandom};
      d[127:32] = {$urandom, $urandom, $urandom};
      send_a(d, 1'b1, ref_sr(d, 4, 1'b1));
      idle_a();
      drain_a();
      chk("postrst_a_cnt", a_cnt, 1);

      // 3. NB=8 table vectors, then feed a live output back inverted
      pulse_reset();
      for (int i = 0; i < 2; i++) send_b(tbl_b[i].din, tbl_b[i].inv, tbl_b[i].exp);
      idle_b();
      drain_b();
      send_b(orig, 1'b0, tbl_b[0].exp);
      idle_b();
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (b_ov) begin
            fb = b_out;
            got = 1;
         end
      end
      if (!got) chk("fb_b_timeout", 0, 1);
      @(posedge clk); #1;
      send_b(fb, 1'b1, orig);
      idle_b();
      drain_b();
      chk("fb_b_cnt", b_cnt, 4);

      // 4. Backpressure on B: output stalled for 5 cycles, 6 blocks offered
      pulse_reset();
      b_acc = 0;
      b_or = 1'b0;
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               d = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
               send_b(d, i[0], ref_sr(d, 8, i[0]));
            end
            idle_b();
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_ov", b_ov, 1);
            chk("bp_hold_first", b_out, qb[0]);
            @(negedge clk);
            chk("bp_ready_low", b_ir, 0);
            chk("bp_accepted", b_acc, 3);
            chk("bp_hold_second", b_out, qb[0]);
            @(posedge clk); #1;
            b_or = 1'b1;
         end
      join
      drain_b();
      chk("bp_b_cnt",  b_cnt, 6);
      chk("bp_b_busy", b_busy, 0);

      // 6. Counter wrap on the 4-bit counter: 17 blocks
      pulse_reset();
      for (int i = 0; i < 17; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
         send_b(d, (i % 3) == 0, ref_sr(d, 8, (i % 3) == 0));
      end
      idle_b();
      drain_b();
      chk("wrap_b_cnt", b_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
